updown_cnt_mod: RTL

//  Parametrised synchronous up/down counter with programmable top value, load, wrap/saturate

---
 rtl/updown_cnt_mod.sv | 81 ++++++++
 1 files changed

// File: rtl/updown_cnt_mod.sv
// Parametrised up/down counter with programmable top value, clamped load, wrap/saturate
// mode, max/min detect, active-low cascade output and boundary-event flags.
module updown_cnt_mod #(
    parameter int WIDTH = 4
) (
    input  logic             cp,
    input  logic             cr_,
    input  logic             ct_,
    input  logic             ld_,
    input  logic             mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] lim,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Mm,
    output logic             RCO_,
    output logic             wrp,
    output logic             ovf
);

    logic             at_bound;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_val;

    // A count cycle taken while at_bound is high is a boundary event.
    always_comb begin
        if (mode) begin
            at_bound = (Q == '0);
        end else begin
            at_bound = (Q >= lim);
        end
    end

    assign Mm   = at_bound;
    assign RCO_ = ~(at_bound & ~ct_);

    assign load_val = (D > lim) ? lim : D;

    always_comb begin
        q_next = Q;
        if (!mode) begin
            if (Q < lim) begin
                q_next = Q + WIDTH'(1);
            end else if (sat) begin
                q_next = lim;
            end else begin
                q_next = '0;
            end
        end else begin
            // Q above lim only happens after lim was lowered; step straight back in.
            if (Q > lim) begin
                q_next = lim;
            end else if (Q == '0) begin
                q_next = sat ? '0 : lim;
            end else begin
                q_next = Q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge cp or negedge cr_) begin
        if (!cr_) begin
            Q   <= '0;
            wrp <= 1'b0;
            ovf <= 1'b0;
        end else if (!ld_) begin
            Q   <= load_val;
            wrp <= 1'b0;
            ovf <= 1'b0;
        end else if (!ct_) begin
            Q   <= q_next;
            wrp <= at_bound;
            if (at_bound) begin
                ovf <= 1'b1;
            end
        end else begin
            wrp <= 1'b0;
        end
    end

endmodule
